// File: rtl/ip_tx_pkg.sv
// Shared definitions for the per-client TX packet buffer: FSM state
// encoding and the bit offsets of the control flags stored above the data
// word in each buffer entry.
package ip_tx_pkg;

   typedef enum logic [1:0] {
      TXB_IDLE = 2'd0,
      TXB_REQ  = 2'd1,
      TXB_XFER = 2'd2
   } txb_state_t;

   // Entry layout is {dwen, eop, sop, data}; offsets are relative to the
   // data width.
   localparam int ENT_SOP_OFS  = 0;
   localparam int ENT_EOP_OFS  = 1;
   localparam int ENT_DWEN_OFS = 2;
   localparam int ENT_CTRL_W   = 3;

endpackage

// File: rtl/ip_tx_pkt_buf_if.sv
// Client-write and arbiter-facing signals of the TX packet buffer.
// master: the client/arbiter side; slave: the buffer itself.
interface ip_tx_pkt_buf_if #(
   parameter int c_DATA_WIDTH = 64,
   parameter int c_ADDR_WIDTH = 5
);
   logic                    wr_en;
   logic [c_DATA_WIDTH-1:0] wr_din;
   logic                    wr_sop;
   logic                    wr_eop;
   logic                    wr_dwen;
   logic                    wr_full;
   logic                    wr_abort;
   logic                    tx_req;
   logic [c_DATA_WIDTH-1:0] tx_dout;
   logic                    tx_sop;
   logic                    tx_eop;
   logic                    tx_dwen;
   logic                    tx_rdy;
   logic [c_ADDR_WIDTH:0]   pkt_cnt;
   logic                    overflow;

   modport master (
      output wr_en, wr_din, wr_sop, wr_eop, wr_dwen, wr_abort, tx_rdy,
      input  wr_full, tx_req, tx_dout, tx_sop, tx_eop, tx_dwen, pkt_cnt, overflow
   );

   modport slave (
      input  wr_en, wr_din, wr_sop, wr_eop, wr_dwen, wr_abort, tx_rdy,
      output wr_full, tx_req, tx_dout, tx_sop, tx_eop, tx_dwen, pkt_cnt, overflow
   );
endinterface

// File: rtl/ip_tx_pkt_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous (show-ahead) read.
module ip_tx_pkt_ram #(
   parameter int c_WIDTH      = 67,
   parameter int c_ADDR_WIDTH = 5
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [c_ADDR_WIDTH-1:0] waddr,
   input  logic [c_WIDTH-1:0]      wdata,
   input  logic [c_ADDR_WIDTH-1:0] raddr,
   output logic [c_WIDTH-1:0]      rdata
);
   logic [c_WIDTH-1:0] mem [2**c_ADDR_WIDTH];

   // Storage write port; contents are not reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/ip_tx_pkt_buf.sv
// Store-and-forward TX packet buffer feeding one arbiter input. Requests the
// arbiter only once a complete packet is held, then streams it bubble-free.
// Optional macro IP_TX_PKT_ABORT_EN enables wr_abort (rewind the write
// pointer to the start of the packet being written).
import ip_tx_pkg::*;

module ip_tx_pkt_buf #(
   parameter int c_DATA_WIDTH = 64,
   parameter int c_ADDR_WIDTH = 5
) (
   input logic             clk,
   input logic             rst,
   ip_tx_pkt_buf_if.slave  bus
);
   localparam int EW = c_DATA_WIDTH + ENT_CTRL_W;
   localparam logic [c_ADDR_WIDTH:0] ONE = 1;

   logic [c_ADDR_WIDTH:0] wr_ptr, rd_ptr, rewind_ptr;
   logic [c_ADDR_WIDTH:0] pkt_cnt_q, pkt_cnt_nxt;
   logic                  overflow_q;
   txb_state_t            state, state_nxt;
   logic [EW-1:0]         wr_entry, head;
   logic                  full, empty, wr_acc, abort_acc, pop, head_eop, tx_req;

   assign full  = (wr_ptr[c_ADDR_WIDTH-1:0] == rd_ptr[c_ADDR_WIDTH-1:0]) &&
                  (wr_ptr[c_ADDR_WIDTH] != rd_ptr[c_ADDR_WIDTH]);
   assign empty = (wr_ptr == rd_ptr);

`ifdef IP_TX_PKT_ABORT_EN
   logic [c_ADDR_WIDTH:0] pkt_start_ptr;
   logic                  pkt_open;

   // An abort only rewinds while a packet is open (SOP seen, EOP not yet).
   assign abort_acc  = bus.wr_abort && pkt_open;
   assign wr_acc     = bus.wr_en && !full && !abort_acc;
   assign rewind_ptr = pkt_start_ptr;

   // Track where the packet currently being written started.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_start_ptr <= '0;
         pkt_open      <= 1'b0;
      end else if (abort_acc) begin
         pkt_open <= 1'b0;
      end else if (wr_acc) begin
         if (bus.wr_sop) begin
            pkt_start_ptr <= wr_ptr;
            pkt_open      <= !bus.wr_eop;
         end else if (bus.wr_eop) begin
            pkt_open <= 1'b0;
         end
      end
   end
`else
   logic unused_abort;
   assign unused_abort = bus.wr_abort;
   assign abort_acc    = 1'b0;
   assign wr_acc       = bus.wr_en && !full;
   assign rewind_ptr   = wr_ptr;
`endif

   assign wr_entry = {bus.wr_dwen, bus.wr_eop, bus.wr_sop, bus.wr_din};

   ip_tx_pkt_ram #(.c_WIDTH(EW), .c_ADDR_WIDTH(c_ADDR_WIDTH)) u_ram (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr[c_ADDR_WIDTH-1:0]),
      .wdata (wr_entry),
      .raddr (rd_ptr[c_ADDR_WIDTH-1:0]),
      .rdata (head)
   );

   // Words only leave while the arbiter has granted us (REQ or XFER).
   assign pop      = bus.tx_rdy && !empty && (state == TXB_REQ || state == TXB_XFER);
   assign head_eop = head[c_DATA_WIDTH + ENT_EOP_OFS];

   // Write pointer: advance on accepted writes, rewind on abort.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            wr_ptr <= '0;
      else if (abort_acc) wr_ptr <= rewind_ptr;
      else if (wr_acc)    wr_ptr <= wr_ptr + ONE;
   end

   // Read pointer, packet count, sticky overflow and FSM state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr     <= '0;
         pkt_cnt_q  <= '0;
         overflow_q <= 1'b0;
         state      <= TXB_IDLE;
      end else begin
         if (pop) rd_ptr <= rd_ptr + ONE;
         pkt_cnt_q <= pkt_cnt_nxt;
         if (bus.wr_en && full && !abort_acc) overflow_q <= 1'b1;
         state <= state_nxt;
      end
   end

   // Complete-packet count and next-state / tx_req decode.
   always_comb begin
      pkt_cnt_nxt = pkt_cnt_q;
      state_nxt   = state;
      tx_req      = 1'b0;
      if ((wr_acc && bus.wr_eop) && !(pop && head_eop)) pkt_cnt_nxt = pkt_cnt_q + ONE;
      else if (!(wr_acc && bus.wr_eop) && (pop && head_eop)) pkt_cnt_nxt = pkt_cnt_q - ONE;
      case (state)
         TXB_IDLE: if (pkt_cnt_q != '0) state_nxt = TXB_REQ;
         TXB_REQ: begin
            tx_req = 1'b1;
            if (pop) begin
               if (!head_eop)              state_nxt = TXB_XFER;
               else if (pkt_cnt_nxt != '0) state_nxt = TXB_REQ;
               else                        state_nxt = TXB_IDLE;
            end
         end
         TXB_XFER: begin
            if (pop && head_eop) state_nxt = (pkt_cnt_nxt != '0) ? TXB_REQ : TXB_IDLE;
         end
         default: state_nxt = TXB_IDLE;
      endcase
   end

   assign bus.tx_req   = tx_req;
   assign bus.tx_dout  = empty ? '0   : head[c_DATA_WIDTH-1:0];
   assign bus.tx_sop   = empty ? 1'b0 : head[c_DATA_WIDTH + ENT_SOP_OFS];
   assign bus.tx_eop   = empty ? 1'b0 : head_eop;
   assign bus.tx_dwen  = empty ? 1'b0 : head[c_DATA_WIDTH + ENT_DWEN_OFS];
   assign bus.wr_full  = full;
   assign bus.pkt_cnt  = pkt_cnt_q;
   assign bus.overflow = overflow_q;
endmodule
